// File: rtl/edge_detect_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
package edge_detect_pkg;

    localparam int unsigned DEF_CHANNELS      = 8;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_FILTER_CYCLES = 4;
    localparam int unsigned DEF_CNT_WIDTH     = 16;

    // popcount operates on a fixed-width vector; narrower channel sets are zero-extended
    localparam int unsigned MAX_CHANNELS = 64;

    function automatic int unsigned fcnt_width(input int unsigned filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

    localparam int unsigned DEF_FCNT_WIDTH = fcnt_width(DEF_FILTER_CYCLES);

    function automatic logic [6:0] popcount(input logic [MAX_CHANNELS-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_CHANNELS; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max_val);
        logic [64:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One channel: synchroniser, stability filter, filtered level and edge pulses.
module edge_detect_chan
    import edge_detect_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = fcnt_width(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
            // this edge completes FILTER_CYCLES consecutive mismatches
            level_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel debounced edge detector with sticky status, irq and
// saturating event counter.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int unsigned CHANNELS      = DEF_CHANNELS,
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  sig_in,
    input  logic [CHANNELS-1:0]  rise_en,
    input  logic [CHANNELS-1:0]  fall_en,
    input  logic [CHANNELS-1:0]  irq_mask,
    input  logic [CHANNELS-1:0]  status_clr,
    input  logic                 count_clr,
    output logic [CHANNELS-1:0]  rise_pulse,
    output logic [CHANNELS-1:0]  fall_pulse,
    output logic [CHANNELS-1:0]  level_out,
    output logic [CHANNELS-1:0]  status,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] edge_count
);

    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        edge_detect_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_chan (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .sig_i  (sig_in[g]),
            .level_o(level_out[g]),
            .rise_o (rise_pulse[g]),
            .fall_o (fall_pulse[g])
        );
    end

    logic [CHANNELS-1:0]  ev;
    logic [CHANNELS-1:0]  status_q, status_d;
    logic                 irq_q, irq_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] count_base;
    logic [6:0]           ev_cnt;

    always_comb begin
        ev         = (rise_pulse & rise_en) | (fall_pulse & fall_en);
        ev_cnt     = popcount(MAX_CHANNELS'(ev));
        // set dominates clear so an event coinciding with a clear is kept
        status_d   = (status_q & ~status_clr) | ev;
        irq_d      = |(status_q & irq_mask);
        count_base = count_clr ? '0 : count_q;
        count_d    = CNT_WIDTH'(sat_add(64'(count_base), 64'(ev_cnt), CNT_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
            count_q  <= count_d;
        end
    end

    assign status     = status_q;
    assign irq        = irq_q;
    assign edge_count = count_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios plus randomized traffic
// checked every cycle against a window-based behavioural model.
module tb_edge_detect_multi;

    localparam int CH = 8;
    localparam int SS = 2;
    localparam int FC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] sig_in = '0, rise_en = '0, fall_en = '0, irq_mask = '0, status_clr = '0;
    logic          count_clr = 1'b0;

    logic [CH-1:0] rise_pulse, fall_pulse, level_out, status;
    logic          irq;
    logic [15:0]   edge_count;
    logic [CH-1:0] rp4, fp4, lv4, st4;
    logic          irq4;
    logic [3:0]    ec4;

    edge_detect_multi #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .rise_en(rise_en), .fall_en(fall_en),
        .irq_mask(irq_mask), .status_clr(status_clr), .count_clr(count_clr),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .level_out(level_out),
        .status(status), .irq(irq), .edge_count(edge_count)
    );

    edge_detect_multi #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(4)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .rise_en(rise_en), .fall_en(fall_en),
        .irq_mask(irq_mask), .status_clr(status_clr), .count_clr(count_clr),
        .rise_pulse(rp4), .fall_pulse(fp4), .level_out(lv4),
        .status(st4), .irq(irq4), .edge_count(ec4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: s seen by the filter is sig_in delayed SS samples;
    // the level flips when the last FC seen samples all differ from it.
    logic [CH-1:0] m_sq  [SS];
    logic [CH-1:0] m_win [FC];
    logic [CH-1:0] m_level, m_rp, m_fp, m_status;
    logic          m_irq;
    int unsigned   m_cnt16, m_cnt4;

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sq[i] = '0;
        for (int i = 0; i < FC; i++) m_win[i] = '0;
        m_level = '0; m_rp = '0; m_fp = '0; m_status = '0;
        m_irq = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
    endtask

    task automatic model_step(input logic [CH-1:0] sin, input logic [CH-1:0] ren,
                              input logic [CH-1:0] fen, input logic [CH-1:0] msk,
                              input logic [CH-1:0] sclr, input logic cclr);
        logic [CH-1:0] s_seen, chg, ev;
        int unsigned   pc, t;
        s_seen = m_sq[SS-1];
        for (int i = SS-1; i > 0; i--) m_sq[i] = m_sq[i-1];
        m_sq[0] = sin;
        for (int i = FC-1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = s_seen;
        chg = '1;
        for (int i = 0; i < FC; i++) chg = chg & (m_win[i] ^ m_level);
        ev = (m_rp & ren) | (m_fp & fen);
        pc = $countones(ev);
        m_irq = |(m_status & msk);
        m_status = (m_status & ~sclr) | ev;
        t = (cclr ? 0 : m_cnt16) + pc;
        m_cnt16 = (t > 65535) ? 65535 : t;
        t = (cclr ? 0 : m_cnt4) + pc;
        m_cnt4 = (t > 15) ? 15 : t;
        m_rp = chg & ~m_level;
        m_fp = chg & m_level;
        m_level = m_level ^ chg;
    endtask

    // Per-cycle compare against the model, 1 time unit after each rising edge.
    initial begin
        logic [CH-1:0] s_sig, s_ren, s_fen, s_msk, s_clr;
        logic          s_cclr, s_rst;
        model_reset();
        forever begin
            @(posedge clk);
            s_sig = sig_in; s_ren = rise_en; s_fen = fall_en;
            s_msk = irq_mask; s_clr = status_clr; s_cclr = count_clr; s_rst = rst_n;
            #1;
            if (!s_rst || !rst_n) model_reset();
            else model_step(s_sig, s_ren, s_fen, s_msk, s_clr, s_cclr);
            chk("rise_pulse", 64'(rise_pulse), 64'(m_rp));
            chk("fall_pulse", 64'(fall_pulse), 64'(m_fp));
            chk("level_out",  64'(level_out),  64'(m_level));
            chk("status",     64'(status),     64'(m_status));
            chk("irq",        64'(irq),        64'(m_irq));
            chk("edge_count", 64'(edge_count), 64'(m_cnt16));
            chk("rise_pulse4", 64'(rp4), 64'(m_rp));
            chk("fall_pulse4", 64'(fp4), 64'(m_fp));
            chk("level_out4",  64'(lv4), 64'(m_level));
            chk("status4",     64'(st4), 64'(m_status));
            chk("irq4",        64'(irq4), 64'(m_irq));
            chk("edge_count4", 64'(ec4), 64'(m_cnt4));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"},  64'(rise_pulse), 64'd0);
        chk({tag, "_fall"},  64'(fall_pulse), 64'd0);
        chk({tag, "_level"}, 64'(level_out),  64'd0);
        chk({tag, "_stat"},  64'(status),     64'd0);
        chk({tag, "_irq"},   64'(irq),        64'd0);
        chk({tag, "_cnt"},   64'(edge_count), 64'd0);
        chk({tag, "_cnt4"},  64'(ec4),        64'd0);
    endtask

    initial begin
        int nr, nf;
        // reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        rise_en = 8'h01;
        @(negedge clk);

        // 1: single rising edge latency on channel 0
        sig_in[0] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk("t1_rise0", 64'(rise_pulse[0]), (k == 5) ? 64'd1 : 64'd0);
            if (k == 5) chk("t1_level0", 64'(level_out[0]), 64'd1);
        end
        chk("t1_status0", 64'(status[0]), 64'd1);
        chk("t1_count", 64'(edge_count), 64'd1);

        // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
        rise_en = 8'h03;
        sig_in[1] = 1'b1;
        nr = 0; nf = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 2) sig_in[1] = 1'b0;
            nr += int'(rise_pulse[1]); nf += int'(fall_pulse[1]);
            chk("t2_glitch_level1", 64'(level_out[1]), 64'd0);
        end
        chk("t2_glitch_pulses", 64'(nr + nf), 64'd0);
        chk("t2_glitch_count", 64'(edge_count), 64'd1);
        sig_in[1] = 1'b1;
        nr = 0; nf = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 3) sig_in[1] = 1'b0;
            nr += int'(rise_pulse[1]); nf += int'(fall_pulse[1]);
        end
        chk("t2_rises", 64'(nr), 64'd1);
        chk("t2_falls", 64'(nf), 64'd1);
        chk("t2_count", 64'(edge_count), 64'd2);

        // 3: all channels rise together with count_clr in the event cycle
        sig_in = '0; fall_en = '0;
        repeat (12) @(negedge clk);
        status_clr = '1;
        @(negedge clk);
        status_clr = '0; rise_en = '1; irq_mask = 8'h01;
        sig_in = '1;
        repeat (6) @(negedge clk);
        chk("t3_rise_all", 64'(rise_pulse), 64'hFF);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        chk("t3_count", 64'(edge_count), 64'd8);
        chk("t3_count4", 64'(ec4), 64'd8);
        chk("t3_status", 64'(status), 64'hFF);
        chk("t3_irq_early", 64'(irq), 64'd0);
        @(negedge clk);
        chk("t3_irq", 64'(irq), 64'd1);

        // 4: clear coinciding with a new event keeps the status bit
        irq_mask = 8'h04; fall_en = 8'h04;
        sig_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_fall2", 64'(fall_pulse[2]), 64'd1);
        status_clr = 8'h04;
        @(negedge clk);
        status_clr = '0;
        chk("t4_status_kept", 64'(status[2]), 64'd1);
        chk("t4_count", 64'(edge_count), 64'd9);
        @(negedge clk);
        chk("t4_irq_on", 64'(irq), 64'd1);
        status_clr = 8'h04;
        @(negedge clk);
        status_clr = '0;
        chk("t4_status_clr", 64'(status[2]), 64'd0);
        chk("t4_irq_lag", 64'(irq), 64'd1);
        @(negedge clk);
        chk("t4_irq_off", 64'(irq), 64'd0);

        // 5: saturation of the 4-bit counter
        rise_en = '1; fall_en = '1;
        for (int r = 0; r < 3; r++) begin
            sig_in = ~sig_in;
            repeat (8) @(negedge clk);
            chk("t5_sat4", 64'(ec4), 64'd15);
        end
        chk("t5_count16", 64'(edge_count), 64'd33);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        chk("t5_clr16", 64'(edge_count), 64'd0);
        chk("t5_clr4", 64'(ec4), 64'd0);

        // 6: async reset mid-filter, input held high through release
        sig_in[1] = ~sig_in[1];
        repeat (2) @(negedge clk);
        sig_in[0] = ~sig_in[0];
        repeat (4) @(negedge clk);
        chk("t6_pulse1", 64'(rise_pulse[1] | fall_pulse[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        sig_in = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            chk("t6_rise", 64'(rise_pulse), (k == 5) ? 64'hFF : 64'h00);
        end
        chk("t6_count", 64'(edge_count), 64'd8);

        // randomized traffic, including a glitchy stretch and a reset
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range((c >= 500 && c < 700) ? 1 : 5) == 0) sig_in[ch] = ~sig_in[ch];
            end
            if ($urandom_range(31) == 0) rise_en = CH'($urandom);
            if ($urandom_range(31) == 0) fall_en = CH'($urandom);
            if ($urandom_range(15) == 0) irq_mask = CH'($urandom);
            status_clr = ($urandom_range(3) == 0) ? CH'($urandom) : '0;
            count_clr = ($urandom_range(63) == 0);
            rst_n = !(c >= 1000 && c < 1002);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Multi-channel successor to the single-signal edge pulse generator.
- Per channel: synchronises an asynchronous input, debounces it with a stability filter, and emits one-cycle rising/falling edge pulses.
- Enabled edges set sticky status bits and drive a global event counter, giving an interrupt source for GPIO/button-style inputs.

Parameters:
- CHANNELS, 8, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 4, consecutive cycles a new level must persist before it is accepted (>=1; 1 = no filtering).
- CNT_WIDTH, 16, width of saturating event counter.

Ports:
- clk, input, 1, single system clock; all flops on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- sig_in, input, CHANNELS, raw asynchronous inputs.
- rise_en, input, CHANNELS, per-channel: rising edges set status / count.
- fall_en, input, CHANNELS, per-channel: falling edges set status / count.
- irq_mask, input, CHANNELS, per-channel interrupt enable.
- status_clr, input, CHANNELS, write-1-to-clear for status bits (level, sampled each cycle).
- count_clr, input, 1, clears edge_count.
- rise_pulse, output, CHANNELS, one-cycle pulse on accepted rising edge (ungated by enables).
- fall_pulse, output, CHANNELS, one-cycle pulse on accepted falling edge (ungated by enables).
- level_out, output, CHANNELS, filtered, synchronised level.
- status, output, CHANNELS, sticky enabled-edge flags.
- irq, output, 1, OR of (status & irq_mask), registered.
- edge_count, output, CNT_WIDTH, saturating count of enabled edges.

Behaviour:
- Reset (async, rst_n=0): sync flops, filter counters, level_out, pulses, status, irq and edge_count all clear to 0 immediately. Reset mid-filtering discards the partial count.
- Sync: sig_in[i] passes through SYNC_STAGES flops to give s[i].
- Filter, per channel: cnt counts consecutive cycles where s != level_out.
  - Any cycle with s == level_out resets cnt to 0 (glitch rejected, no pulse).
  - On the edge where the mismatch has lasted FILTER_CYCLES cycles, level_out <= s and cnt <= 0.
- Latency: if sig_in first samples a new level at edge E0, level_out changes and the corresponding pulse is high for exactly one cycle following edge E0+SYNC_STAGES+FILTER_CYCLES-1. With defaults, that is the cycle after E0+5.
  - A pulse of sig_in shorter than FILTER_CYCLES synchronised cycles produces no pulses.
  - Max one edge per channel per FILTER_CYCLES cycles.
- Pulse generation: rise_pulse[i]=1 iff level_out[i] went 0->1 at that edge; fall_pulse[i]=1 iff it went 1->0. Never both high together.
- Event: ev[i] = (rise_pulse[i]&rise_en[i]) | (fall_pulse[i]&fall_en[i]), evaluated combinationally from the registered pulses.
- status[i]: set when ev[i], cleared when status_clr[i]. If both occur in the same cycle, set wins (no lost event). Updates on the edge after ev.
- irq: registered; irq = |(status & irq_mask) one cycle after status. Mask changes take effect with the same one-cycle latency.
- edge_count:
  - Each cycle: edge_count <= sat(edge_count + popcount(ev)).
  - Saturates at 2^CNT_WIDTH-1 and holds there; it never wraps.
  - count_clr with simultaneous events: edge_count <= sat(popcount(ev)).
- Power-up level: level_out resets to 0. An input held at 1 through reset release produces one rise_pulse after the normal latency. This is intended; software masks via rise_en during init.
- Enables do not affect filtering or the pulse outputs, only status and count.

Decomposition:
- Package edge_detect_pkg:
  - default parameter constants;
  - a popcount function for CHANNELS-wide vectors;
  - a saturating-add helper;
  - filter counter width = $clog2(FILTER_CYCLES+1).
- Sub-module edge_detect_chan: sync chain, filter counter, level_out register, rise/fall pulse for one channel. It is instantiated CHANNELS times in a generate loop.
- The top holds status, irq and edge_count.

Test Plan:
1. Reset, then sig_in[0] 0->1 sampled at edge E0, held; defaults, rise_en[0]=1 -> rise_pulse[0] high only in the cycle after E0+5, level_out[0]=1, status[0]=1 one cycle later, edge_count=1.
2. sig_in[1] glitch high for 3 cycles (FILTER_CYCLES=4) -> no rise/fall pulse, level_out[1] stays 0, edge_count unchanged. A 4-cycle high -> exactly one rise and one later fall pulse.
3. All 8 channels rise in the same cycle, rise_en=8'hFF, count_clr asserted that cycle -> edge_count=8, status=8'hFF. With irq_mask=8'h01, irq=1 the next cycle.
4. status[2] set; status_clr[2] asserted in the same cycle as a new enabled fall on channel 2 -> status[2] remains 1. A later clear alone -> status[2]=0 and irq drops the next cycle.
5. CNT_WIDTH=4: generate 20 enabled edges -> edge_count stops at 15 and holds; count_clr -> 0.
6. Assert rst_n=0 mid-filter (cnt=2) with pulses and status nonzero -> all outputs 0 asynchronously. sig_in held 1 across reset release -> one rise_pulse after E0+5.
